// File: rtl/fpga_mode_sequencer.sv
// fpga_mode_sequencer: SPI config decoder with guarded quiesce/switch/settle mode changes; FPGA_MODE_READBACK_EN adds miso readback
module fpga_mode_sequencer #(
    parameter int GUARD_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic       spcki,
    input  logic       mosi,
    input  logic       ncs,
    output logic       miso,
    output logic [7:0] conf_word,
    output logic [7:0] divisor,
    output logic       outputs_quiet,
    output logic       mode_valid,
    output logic [7:0] err_count
);
    localparam logic [1:0] IDLE = 2'd0, QUIESCE = 2'd1, SWITCH = 2'd2, SETTLE = 2'd3;
    localparam int CW = $clog2((GUARD_CYCLES > SETTLE_CYCLES ? GUARD_CYCLES : SETTLE_CYCLES) + 1);
    localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

    logic [2:0] sck_s, ncs_s;
    logic [1:0] mosi_s;
    logic [15:0] sr;
    logic [4:0] bcnt;
    logic [1:0] state, base, next_state;
    logic [CW-1:0] cnt;
    logic [7:0] target, pend;
    logic pend_v, pend_go, to_pend;
    logic sck_rise, ncs_rise, ncs_fall, frame_ok, set_conf, set_div, bad;

    // [1] is the synchronized level, [2] the previous level for edge detection; ncs idles high
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            sck_s  <= 3'b000;
            ncs_s  <= 3'b111;
            mosi_s <= 2'b00;
        end else begin
            sck_s  <= {sck_s[1:0], spcki};
            ncs_s  <= {ncs_s[1:0], ncs};
            mosi_s <= {mosi_s[0], mosi};
        end
    end

    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign ncs_rise = ncs_s[1] & ~ncs_s[2];
    assign ncs_fall = ~ncs_s[1] & ncs_s[2];
    assign frame_ok = ncs_rise && bcnt == 5'd16;
    assign set_conf = frame_ok && sr[15:12] == 4'd1;
    assign set_div  = frame_ok && sr[15:12] == 4'd2;
    assign bad      = ncs_rise && !(set_conf || set_div);

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            sr   <= '0;
            bcnt <= '0;
        end else if (ncs_fall) begin
            bcnt <= '0;
        end else if (!ncs_s[1] && sck_rise) begin
            sr   <= {sr[14:0], mosi_s[1]};
            bcnt <= bcnt + {4'd0, ~&bcnt};
        end
    end

    // a strobe coinciding with a transition is judged against the state being entered
    always_comb begin
        pend_go    = pend_v && pend != conf_word;
        base       = state == QUIESCE ? (cnt == '0 ? SWITCH : QUIESCE) :
                     state == SWITCH  ? SETTLE :
                     state == SETTLE  ? (cnt == '0 ? (pend_go ? QUIESCE : IDLE) : SETTLE) : IDLE;
        next_state = (set_conf && base == IDLE && sr[7:0] != conf_word) ? QUIESCE : base;
        to_pend    = set_conf && (next_state == SWITCH || next_state == SETTLE);
    end

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            state     <= SETTLE;
            cnt       <= SETTLE_LD;
            target    <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            conf_word <= '0;
            divisor   <= 8'd95;
            err_count <= '0;
        end else begin
            state <= next_state;
            cnt   <= (next_state == QUIESCE && state != QUIESCE) ? GUARD_LD :
                     (next_state == SETTLE && state != SETTLE) ? SETTLE_LD : cnt - CW'(cnt != '0);
            if (set_conf && next_state == QUIESCE)
                target <= sr[7:0];
            else if (state == SETTLE && next_state == QUIESCE)
                target <= pend;
            if (to_pend)
                pend <= sr[7:0];
            pend_v <= to_pend || (pend_v && !(state == SETTLE && next_state != SETTLE));
            if (state == SWITCH)
                conf_word <= target;
            if (set_div)
                divisor <= sr[7:0];
            err_count <= err_count + {7'd0, bad && err_count != 8'hFF};
        end
    end

    assign outputs_quiet = state != IDLE;
    assign mode_valid    = ~outputs_quiet;

`ifdef FPGA_MODE_READBACK_EN
    logic [15:0] rb;
    logic sck_fall;
    assign sck_fall = ~sck_s[1] & sck_s[2];
    always_ff @(posedge ck_1356meg) begin
        if (rst)
            rb <= '0;
        else if (ncs_fall)
            rb <= {8'h10, conf_word};
        else if (!ncs_s[1] && sck_fall)
            rb <= {rb[14:0], 1'b0};
    end
    assign miso = rb[15];
`else
    assign miso = 1'b0;
`endif
endmodule

// File: tb/tb_fpga_mode_sequencer.sv
// tb_fpga_mode_sequencer: vector table, timed corner sequences and random frames against a transaction-level model
module tb_fpga_mode_sequencer;
    localparam int GL = 120;
    localparam int SL = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spcki = 1'b0;
    logic mosi = 1'b0;
    logic ncs = 1'b1;
    logic miso, quiet, valid, miso_l, quiet_l, valid_l;
    logic [7:0] conf, div, err, conf_l, div_l, err_l;

    int nvec = 0;
    int nmis = 0;
    logic [15:0] rb_cap;

    always #5 clk = ~clk;

    fpga_mode_sequencer dut (
        .ck_1356meg(clk), .rst(rst), .spcki(spcki), .mosi(mosi), .ncs(ncs), .miso(miso),
        .conf_word(conf), .divisor(div), .outputs_quiet(quiet), .mode_valid(valid), .err_count(err)
    );

    fpga_mode_sequencer #(.GUARD_CYCLES(GL), .SETTLE_CYCLES(SL)) dut_l (
        .ck_1356meg(clk), .rst(rst), .spcki(spcki), .mosi(mosi), .ncs(ncs), .miso(miso_l),
        .conf_word(conf_l), .divisor(div_l), .outputs_quiet(quiet_l), .mode_valid(valid_l), .err_count(err_l)
    );

    typedef struct {
        logic [63:0] w;
        int nb;
        logic q1;
        logic [7:0] conf, div, err;
    } vec_t;

    vec_t tbl[8];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // returns at the negedge where ncs is raised; the frame strobe follows two cycles later
    task automatic send_frame(input logic [63:0] w, input int nb, input int ph);
        rb_cap = '0;
        ncs = 1'b0;
        tick(ph);
        for (int i = nb - 1; i >= 0; i--) begin
            mosi = w[i];
            tick(ph);
            rb_cap = {rb_cap[14:0], miso};
            spcki = 1'b1;
            tick(ph);
            spcki = 1'b0;
        end
        tick(ph);
        ncs = 1'b1;
    endtask

    initial begin
        logic [7:0] m_conf, m_div, m_err, r8;
        logic [63:0] w;
        int nb, ph, drops, badv;
        tbl[0] = '{64'h1005, 15, 1'b0, 8'h03, 8'h5F, 8'd1};
        tbl[1] = '{64'h1005, 17, 1'b0, 8'h03, 8'h5F, 8'd2};
        tbl[2] = '{64'h7000, 16, 1'b0, 8'h03, 8'h5F, 8'd3};
        tbl[3] = '{64'h1003, 16, 1'b0, 8'h03, 8'h5F, 8'd3};
        tbl[4] = '{64'h2042, 16, 1'b0, 8'h03, 8'h42, 8'd3};
        tbl[5] = '{64'h0000, 16, 1'b0, 8'h03, 8'h42, 8'd4};
        tbl[6] = '{64'h1011, 16, 1'b1, 8'h11, 8'h42, 8'd4};
        tbl[7] = '{64'h1055, 48, 1'b0, 8'h11, 8'h42, 8'd5};

        tick(3);
        chk("rst_conf", conf, 8'h00);
        chk("rst_div", div, 8'd95);
        chk("rst_err", err, 8'd0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_miso", miso, 1'b0);
        rst = 1'b0;
        tick(31);
        chk("post_rst_valid_31", valid, 1'b0);
        tick(1);
        chk("post_rst_valid_32", valid, 1'b1);

        send_frame(64'h1003, 16, 3);
        tick(1);
        chk("a_quiet_tm1", quiet, 1'b0);
        tick(2);
        chk("a_quiet_t1", quiet, 1'b1);
        tick(16);
        chk("a_conf_t17", conf, 8'h00);
        tick(1);
        chk("a_conf_t18", conf, 8'h03);
        tick(31);
        chk("a_valid_t49", valid, 1'b0);
        tick(1);
        chk("a_valid_t50", valid, 1'b1);

        send_frame(64'h20A5, 16, 3);
        tick(2);
        chk("b_div_t0", div, 8'h5F);
        tick(1);
        chk("b_div_t1", div, 8'hA5);
        chk("b_quiet_t1", quiet, 1'b0);
        chk("b_conf_t1", conf, 8'h03);
        tick(3);
        send_frame(64'h205F, 16, 3);
        tick(3);
        chk("b_div2_t1", div, 8'h5F);
        tick(10);

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].w, tbl[i].nb, 3);
            tick(3);
            chk($sformatf("tbl%0d_quiet", i), quiet, tbl[i].q1);
            tick(57);
            chk($sformatf("tbl%0d_conf", i), conf, tbl[i].conf);
            chk($sformatf("tbl%0d_div", i), div, tbl[i].div);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
            chk($sformatf("tbl%0d_valid", i), valid, 1'b1);
        end

        tick(700);
        chk("l_conf_pre", conf_l, 8'h11);
        chk("l_valid_pre", valid_l, 1'b1);
        send_frame(64'h1020, 16, 3);
        drops = 0;
        badv = 0;
        fork
            begin
                tick(3);
                send_frame(64'h1040, 16, 3);
                tick(3);
                send_frame(64'h1060, 16, 3);
                tick(3);
                send_frame(64'h1080, 16, 3);
            end
            begin
                for (int k = -1; k <= 2 + GL + SL + 2 + GL + SL; k++) begin
                    tick(1);
                    if (k == 0) chk("l_quiet_t0", quiet_l, 1'b0);
                    if (k >= 1 && k <= 2 * (GL + SL) + 2 && !quiet_l) drops++;
                    if (conf_l == 8'h20 || conf_l == 8'h60) badv++;
                    if (k == GL + 1) chk("l_conf_before_switch", conf_l, 8'h11);
                    if (k == GL + 2) chk("l_conf_replaced", conf_l, 8'h40);
                    if (k == 2 * GL + SL + 2) chk("l_conf_before_2nd", conf_l, 8'h40);
                    if (k == 2 * GL + SL + 3) chk("l_conf_last_wins", conf_l, 8'h80);
                    if (k == 2 * (GL + SL) + 2) chk("l_valid_end_m1", valid_l, 1'b0);
                    if (k == 2 * (GL + SL) + 3) chk("l_valid_end", valid_l, 1'b1);
                end
            end
        join
        chk("l_quiet_gaps", drops, 0);
        chk("l_discarded_seen", badv, 0);
        chk("d_conf_chain", conf, 8'h80);

        send_frame(64'h1033, 16, 3);
        tick(32);
        chk("r_in_settle", quiet, 1'b1);
        rst = 1'b1;
        tick(2);
        chk("r_conf", conf, 8'h00);
        chk("r_div", div, 8'd95);
        chk("r_err", err, 8'd0);
        chk("r_valid", valid, 1'b0);
        rst = 1'b0;
        tick(31);
        chk("r_valid_31", valid, 1'b0);
        tick(1);
        chk("r_valid_32", valid, 1'b1);

        send_frame(64'h1003, 16, 3);
        tick(60);
        send_frame(64'h2077, 16, 3);
`ifdef FPGA_MODE_READBACK_EN
        chk("readback", rb_cap, 16'h1003);
`else
        chk("readback", rb_cap, 16'h0000);
`endif
        tick(5);

        m_conf = 8'h03;
        m_div = 8'h77;
        m_err = 8'd0;
        for (int i = 0; i < 24; i++) begin
            r8 = 8'($urandom);
            nb = 16;
            case ($urandom_range(0, 3))
                0: begin w = {48'd0, 8'h10, r8}; m_conf = r8; end
                1: begin w = {48'd0, 8'h20, r8}; m_div = r8; end
                2: begin
                    w = {48'd0, 4'($urandom_range(3, 15)), 4'($urandom), r8};
                    m_err = m_err == 8'hFF ? m_err : m_err + 8'd1;
                end
                default: begin
                    w = {32'd0, $urandom};
                    nb = $urandom_range(0, 1) ? $urandom_range(12, 15) : $urandom_range(17, 20);
                    m_err = m_err == 8'hFF ? m_err : m_err + 8'd1;
                end
            endcase
            ph = $urandom_range(3, 5);
            send_frame(w, nb, ph);
            tick(3);
            chk($sformatf("rnd%0d_div", i), div, m_div);
            chk($sformatf("rnd%0d_err", i), err, m_err);
            tick($urandom_range(3, 60));
        end
        tick(800);
        chk("rnd_conf", conf, m_conf);
        chk("rnd_conf_l", conf_l, m_conf);
        chk("rnd_div_l", div_l, m_div);
        chk("rnd_err_l", err_l, m_err);
        chk("rnd_valid", valid, 1'b1);
        chk("rnd_valid_l", valid_l, 1'b1);

        for (int i = 0; i < 260; i++) begin
            send_frame(64'h1, 1, 3);
            m_err = m_err == 8'hFF ? m_err : m_err + 8'd1;
            tick(3);
        end
        tick(5);
        chk("sat_err", err, m_err);
        chk("sat_err_l", err_l, m_err);
        chk("sat_conf", conf, m_conf);
        chk("end_miso", miso, 1'b0);
        chk("end_miso_l", miso_l, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
